// File: rtl/fifo_spram_2bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_spram_2bank
// Purpose  : Valid/ready FIFO on two single-port RAM banks (even/odd entries).
//            It sustains one push and one pop per cycle. A one-entry hold
//            register absorbs pushes that collide with a read on the same
//            bank. A 2-entry register prefetch stage drives the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_spram_2bank #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int AF_THRESH  = FIFO_DEPTH - 2,
  parameter  int AE_THRESH  = 2,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty
);

  localparam int BANK_DEPTH = FIFO_DEPTH / 2;
  localparam logic [CNT_WIDTH-1:0] c_ram_full = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_af       = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] c_ae       = CNT_WIDTH'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_waddr, r_raddr, r_hold_addr;
  logic [CNT_WIDTH-1:0]  r_ram_cnt, r_count;
  logic                  r_hold_valid, r_inflight, r_rd_bank, r_rd_fwd;
  logic [DATA_WIDTH-1:0] r_hold_data, r_fwd_data, r_pf_data0, r_pf_data1;
  logic [1:0]            r_pf_cnt;

  logic                  w_push, w_pop, w_rd_req, w_push_conflict, w_fwd;
  logic [2:0]            w_pf_need;
  logic [DATA_WIDTH-1:0] w_rd_data, w_pf0_nxt, w_pf1_nxt;
  logic [1:0]            w_pf_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_bank_q0, w_bank_q1;

  assign o_in_ready  = (r_ram_cnt < c_ram_full) & ~i_flush;
  assign o_out_valid = (r_pf_cnt != 2'd0);
  assign o_out_data  = r_pf_data0;
  assign o_count     = r_count;
  assign o_almost_full  = (r_count >= c_af);
  assign o_almost_empty = (r_count <= c_ae);

  assign w_push = i_in_valid & o_in_ready;
  assign w_pop  = o_out_valid & i_out_ready;

  // Entries the prefetch stage will hold once in-flight data lands and this pop leaves.
  assign w_pf_need = {1'b0, r_pf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_req  = (r_ram_cnt != '0) & (w_pf_need < 3'd2) & ~i_flush;

  // A push must detour through the hold register when its bank is busy with the read or a hold drain.
  assign w_push_conflict = w_push &
                           ((w_rd_req & (r_raddr[0] == r_waddr[0])) |
                            (r_hold_valid & (r_hold_addr[0] == r_waddr[0])));
  assign w_fwd = r_hold_valid & (r_hold_addr == r_raddr);

  assign w_rd_data = r_rd_fwd ? r_fwd_data : (r_rd_bank ? w_bank_q1 : w_bank_q0);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  w_re, w_hold_we, w_push_we;
    logic [ADDR_WIDTH-2:0] w_wrow;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_re      = w_rd_req & (r_raddr[0] == 1'(b));
    assign w_hold_we = ~i_flush & r_hold_valid & (r_hold_addr[0] == 1'(b));
    assign w_push_we = w_push & ~w_push_conflict & (r_waddr[0] == 1'(b));
    assign w_wrow    = w_hold_we ? r_hold_addr[ADDR_WIDTH-1:1] : r_waddr[ADDR_WIDTH-1:1];
    assign w_wdata   = w_hold_we ? r_hold_data : i_in_data;

    // Single-port bank: one read or one write per cycle, read wins.
    always_ff @(posedge clk) begin
      if (w_re) begin
        r_q <= r_mem[r_raddr[ADDR_WIDTH-1:1]];
      end else if (w_hold_we | w_push_we) begin
        r_mem[w_wrow] <= w_wdata;
      end
    end
  end

  assign w_bank_q0 = g_bank[0].r_q;
  assign w_bank_q1 = g_bank[1].r_q;

  // Prefetch next state: pop shifts entry 1 down, returning read data fills the first free slot.
  always_comb begin
    w_pf0_nxt    = r_pf_data0;
    w_pf1_nxt    = r_pf_data1;
    w_pf_cnt_nxt = r_pf_cnt;
    if (w_pop) begin
      w_pf0_nxt    = r_pf_data1;
      w_pf_cnt_nxt = w_pf_cnt_nxt - 2'd1;
    end
    if (r_inflight) begin
      if (w_pf_cnt_nxt == 2'd0) begin
        w_pf0_nxt = w_rd_data;
      end else begin
        w_pf1_nxt = w_rd_data;
      end
      w_pf_cnt_nxt = w_pf_cnt_nxt + 2'd1;
    end
  end

  // Pointers, occupancy, hold register, read pipeline and prefetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr      <= '0;
      r_raddr      <= '0;
      r_ram_cnt    <= '0;
      r_count      <= '0;
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_inflight   <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_rd_fwd     <= 1'b0;
      r_fwd_data   <= '0;
      r_pf_data0   <= '0;
      r_pf_data1   <= '0;
      r_pf_cnt     <= 2'd0;
    end else if (i_flush) begin
      r_waddr      <= '0;
      r_raddr      <= '0;
      r_ram_cnt    <= '0;
      r_count      <= '0;
      r_hold_valid <= 1'b0;
      r_inflight   <= 1'b0;
      r_rd_fwd     <= 1'b0;
      r_pf_cnt     <= 2'd0;
    end else begin
      r_waddr   <= r_waddr + ADDR_WIDTH'(w_push);
      r_raddr   <= r_raddr + ADDR_WIDTH'(w_rd_req);
      r_ram_cnt <= r_ram_cnt + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_rd_req);
      r_count   <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
      r_hold_valid <= w_push_conflict;
      if (w_push_conflict) begin
        r_hold_addr <= r_waddr;
        r_hold_data <= i_in_data;
      end
      r_inflight <= w_rd_req;
      if (w_rd_req) begin
        r_rd_bank  <= r_raddr[0];
        r_rd_fwd   <= w_fwd;
        r_fwd_data <= r_hold_data;
      end
      r_pf_data0 <= w_pf0_nxt;
      r_pf_data1 <= w_pf1_nxt;
      r_pf_cnt   <= w_pf_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_spram_2bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_spram_2bank
// Purpose  : Scoreboard bench for fifo_spram_2bank. Accepted pushes are queued
//            and a monitor compares every pop, the count and the flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_spram_2bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, almost_full, almost_empty;
  logic [7:0] out_data;
  logic [4:0] count;

  fifo_spram_2bank #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .o_out_data     (out_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_count        (count),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         exp_count = 0;
  int         cyc = 0;
  int         npops = 0;
  int         first_pop = -1;
  int         last_pop = -1;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_almost_full"}, int'(almost_full), 0);
    chk({tag, "_almost_empty"}, int'(almost_empty), 1);
  endtask

  // Stimulus side of the scoreboard: every accepted push queues its expected pop.
  always @(negedge clk) begin
    if (rst_n && !flush && in_valid && in_ready) sb.push_back(in_data);
  end

  // Monitor: pops against the scoreboard, count/flag model, output stability under backpressure.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("count", int'(count), exp_count);
      chk("almost_full", int'(almost_full), int'(exp_count >= 14));
      chk("almost_empty", int'(almost_empty), int'(exp_count <= 2));
      if (prev_hold) chk("out_data_stable", int'(out_data), int'(prev_data));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_with_empty_scoreboard", 1, 0);
        end else begin
          chk("pop_data", int'(out_data), int'(sb.pop_front()));
        end
        npops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (flush) begin
        exp_count = 0;
        sb.delete();
      end else begin
        exp_count = exp_count + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_data = out_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    int base;
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("reset");

    // Single push: out_valid appears exactly three cycles after the push cycle
    out_ready = 1'b1;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", int'(out_valid), 0);
    tick();
    chk("lat_cycle2_valid", int'(out_valid), 0);
    tick();
    chk("lat_cycle3_valid", int'(out_valid), 1);
    chk("lat_cycle3_data", int'(out_data), 8'hA5);
    chk("lat_cycle3_count", int'(count), 1);
    tick();
    chk("lat_after_pop_count", int'(count), 0);
    tick();

    // Stream 0..63 with both sides always ready
    base = npops;
    first_pop = -1;
    for (int i = 0; i < 64; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      if (in_ready !== 1'b1) chk("stream_in_ready", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("stream_pops", npops - base, 64);
    chk("stream_back_to_back", last_pop - first_pop, 63);

    // Fill with consumer stalled: 16 in RAM + 2 in prefetch, extra pushes refused
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      in_data  = 8'(100 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("full_count", int'(count), 18);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_almost_full", int'(almost_full), 1);
    chk("full_out_data", int'(out_data), 100);
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("full_drained_count", int'(count), 0);
    chk("full_drained_sb", sb.size(), 0);

    // Random traffic: both handshakes toggle, bank conflicts go through the hold register
    for (int i = 0; i < 3000; i++) begin
      in_data   = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("random_drained_sb", sb.size(), 0);
    chk("random_drained_count", int'(count), 0);

    // Flush with 10 entries held and a push attempted in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data  = 8'(200 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("preflush_count", int'(count), 10);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_almost_empty", int'(almost_empty), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("flush_dropped_push", int'(out_valid), 0);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a stream, then a fresh stream 0..7
    for (int i = 0; i < 6; i++) begin
      in_data  = 8'(50 + i);
      in_valid = 1'b1;
      tick();
    end
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    exp_count = 0;
    tick();
    rst_n = 1'b1;
    tick();
    base = npops;
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("post_reset_pops", npops - base, 8);
    chk("post_reset_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
